// File: rtl/alu_cmd_queue.sv
// Command FIFO and result-capture stage around a combinational 4-bit ALU.
// Commands queue over valid/ready; the head drives the ALU and its result is registered for the consumer.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_a,
    input  logic [3:0]              in_b,
    input  logic [3:0]              in_opcode,
    output logic [3:0]              alu_a,
    output logic [3:0]              alu_b,
    output logic [3:0]              alu_opcode,
    input  logic [3:0]              alu_x,
    input  logic [3:0]              alu_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_x,
    output logic [3:0]              out_y,
    output logic [3:0]              out_opcode,
    output logic [$clog2(DEPTH):0]  count,
    output logic [CNT_W-1:0]        done_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] opcode;
    } cmd_t;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             not_empty;
    res_state_t       res_state;

    // in_ready depends only on registered occupancy, never on out_ready
    assign not_empty  = (count != '0);
    assign in_ready   = (count < FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = not_empty && (!out_valid || out_ready);
    assign out_valid  = (res_state == RES_FULL);

    assign head       = mem[rd_ptr];
    assign alu_a      = not_empty ? head.a      : 4'h0;
    assign alu_b      = not_empty ? head.b      : 4'h0;
    assign alu_opcode = not_empty ? head.opcode : 4'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_opcode};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result register: a pop always refills it, even while the old result is being handed off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_state  <= RES_EMPTY;
            out_x      <= 4'h0;
            out_y      <= 4'h0;
            out_opcode <= 4'h0;
        end else begin
            case (res_state)
                RES_EMPTY: if (pop) res_state <= RES_FULL;
                RES_FULL:  if (out_ready && !pop) res_state <= RES_EMPTY;
            endcase
            if (pop) begin
                out_x      <= alu_x;
                out_y      <= alu_y;
                out_opcode <= head.opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule
